h14tx_symbol_mux: RTL and testbench



---
 rtl/h14tx_symbol_mux_pkg.sv | 42 ++++
 rtl/h14tx_symbol_mux_if.sv | 13 +
 rtl/h14tx_tmds_encoder.sv | 57 +++++
 rtl/h14tx_symbol_mux.sv | 61 ++++++
 tb/tb_h14tx_symbol_mux.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/h14tx_symbol_mux_pkg.sv
// Shared types and constants for the HDMI 1.4 TMDS symbol path.
package h14tx_pkg;

  typedef enum logic [1:0] {
    PER_CONTROL  = 2'd0,
    PER_ACTIVE   = 2'd1,
    PER_PREAMBLE = 2'd2,
    PER_GUARD    = 2'd3
  } period_t;

  typedef logic [9:0]        symbol_t;
  typedef logic signed [4:0] disparity_t;

  // Indexed by {d1,d0}
  localparam symbol_t CtlToken [0:3] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam symbol_t VideoGuardCh0 = 10'b1011001100;
  localparam symbol_t VideoGuardCh1 = 10'b0100110011;
  localparam symbol_t VideoGuardCh2 = 10'b1011001100;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    return 4'($countones(d));
  endfunction

  // Transition-minimising stage: XOR or XNOR chain, q_m[8] flags XOR.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    return qm;
  endfunction

endpackage

// File: rtl/h14tx_symbol_mux_if.sv
// Pixel/period input bundle and per-channel symbol output of the symbol mux.
interface h14tx_symbol_mux_if;
  import h14tx_pkg::*;

  period_t          timings;
  logic [23:0]      pixel;
  logic             hsync;
  logic             vsync;
  symbol_t [2:0]    symbols;

  modport master (output timings, pixel, hsync, vsync, input symbols);
  modport slave  (input timings, pixel, hsync, vsync, output symbols);
endinterface

// File: rtl/h14tx_tmds_encoder.sv
// One TMDS channel: S1 registers q_m from raw data, S2 does DC balance or
// emits a control/guard symbol. data_i is S0-timed, all other inputs S1-timed.
module h14tx_tmds_encoder
  import h14tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       en_active_i,
  input  logic       en_guard_i,
  input  logic [1:0] ctrl_i,
  input  symbol_t    guard_i,
  output symbol_t    sym_o
);

  logic [8:0] q_m_q;
  symbol_t    sym_q, sym_d;
  disparity_t cnt_q, cnt_d;
  logic [3:0] n1q;
  disparity_t bal, two_q8, two_nq8;

  always_comb begin
    n1q     = popcount8(q_m_q[7:0]);
    bal     = $signed({n1q, 1'b0}) - 5'sd8;   // N1 - N0
    two_q8  = {3'b000, q_m_q[8], 1'b0};
    two_nq8 = {3'b000, ~q_m_q[8], 1'b0};
    sym_d   = CtlToken[ctrl_i];
    cnt_d   = '0;
    if (!en_active_i) begin
      sym_d = en_guard_i ? guard_i : CtlToken[ctrl_i];
    end else if (cnt_q == '0 || bal == '0) begin
      sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      cnt_d = q_m_q[8] ? cnt_q + bal : cnt_q - bal;
    end else if ((cnt_q > 0 && bal > 0) || (cnt_q < 0 && bal < 0)) begin
      sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d = cnt_q + two_q8 - bal;
    end else begin
      sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d = cnt_q - two_nq8 + bal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_m_q <= '0;
      sym_q <= CtlToken[0];
      cnt_q <= '0;
    end else begin
      q_m_q <= tmds_qm(data_i);
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/h14tx_symbol_mux.sv
// Three-channel HDMI 1.4 symbol generator: period decode, S1 delay-matching
// of period/syncs, and one TMDS encoder per channel.
module h14tx_symbol_mux
  import h14tx_pkg::*;
#(
  parameter bit DviMode = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  h14tx_symbol_mux_if.slave  bus
);

  localparam symbol_t GuardSym [3] = '{VideoGuardCh0, VideoGuardCh1, VideoGuardCh2};

  period_t          per_s1_q;
  logic             hs_s1_q, vs_s1_q;
  logic [23:0]      data_s0;
  logic             en_active_s1, en_guard_s1;
  logic [2:0][1:0]  ctrl_s1;
  symbol_t [2:0]    sym;

  // Pixel is zeroed outside active video so nothing undefined reaches q_m.
  assign data_s0 = (bus.timings == PER_ACTIVE) ? bus.pixel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_s1_q <= PER_CONTROL;
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
    end else begin
      per_s1_q <= bus.timings;
      hs_s1_q  <= bus.hsync;
      vs_s1_q  <= bus.vsync;
    end
  end

  always_comb begin
    en_active_s1 = (per_s1_q == PER_ACTIVE);
    en_guard_s1  = (per_s1_q == PER_GUARD) && !DviMode;
    ctrl_s1[0]   = {vs_s1_q, hs_s1_q};
    ctrl_s1[1]   = 2'b00;
    ctrl_s1[2]   = 2'b00;
    if (per_s1_q == PER_PREAMBLE && !DviMode) ctrl_s1[1] = 2'b01;
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    h14tx_tmds_encoder u_enc (
      .clk         (clk),
      .rst         (rst),
      .data_i      (data_s0[8*g +: 8]),
      .en_active_i (en_active_s1),
      .en_guard_i  (en_guard_s1),
      .ctrl_i      (ctrl_s1[g]),
      .guard_i     (GuardSym[g]),
      .sym_o       (sym[g])
    );
  end

  assign bus.symbols = sym;

endmodule

// File: tb/tb_h14tx_symbol_mux.sv
// Scoreboard bench for h14tx_symbol_mux: HDMI (DviMode=0) and DVI (DviMode=1)
// instances share stimulus; expectations come from a DVI 1.0 reference model.
module tb_h14tx_symbol_mux;
  import h14tx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  h14tx_symbol_mux_if if0 ();
  h14tx_symbol_mux_if if1 ();

  h14tx_symbol_mux #(.DviMode(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  h14tx_symbol_mux #(.DviMode(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    symbol_t [2:0] e0;
    symbol_t [2:0] e1;
    bit            act;
    logic [23:0]   pix;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  string       phase = "reset";

  period_t     m_per;
  logic        m_hs, m_vs;
  logic [23:0] m_pix;
  int          m_cnt [3];

  task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
  endtask

  function automatic symbol_t tok(input logic [1:0] d);
    case (d)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference DVI 1.0 encoder with integer disparity.
  function automatic symbol_t tmds_ref(input logic [7:0] d, inout int cnt);
    logic [8:0] qm;
    symbol_t    s;
    int         n1d, n1, n0;
    bit         xn;
    n1d   = $countones(d);
    xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8] == 1'b0) cnt = cnt + n0 - n1;
      else               cnt = cnt + n1 - n0;
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      s   = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + 2 * int'(qm[8]) + n0 - n1;
    end else begin
      s   = {1'b0, qm[8], qm[7:0]};
      cnt = cnt - 2 * int'(!qm[8]) + n1 - n0;
    end
    return s;
  endfunction

  function automatic logic [7:0] tmds_dec(input symbol_t s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // Drive one cycle, push the model's expectation for this edge, then compare.
  task automatic step(input logic r, input period_t p, input logic [23:0] px,
                      input logic hs, input logic vs);
    exp_t e, o;
    rst = r;
    if0.timings = p;  if0.pixel = px;  if0.hsync = hs;  if0.vsync = vs;
    if1.timings = p;  if1.pixel = px;  if1.hsync = hs;  if1.vsync = vs;
    e.act = 1'b0;
    e.pix = m_pix;
    if (r) begin
      for (int c = 0; c < 3; c++) begin
        e.e0[c] = tok(2'b00); e.e1[c] = tok(2'b00); m_cnt[c] = 0;
      end
      m_per = PER_CONTROL; m_hs = 1'b0; m_vs = 1'b0; m_pix = '0;
    end else begin
      if (m_per == PER_ACTIVE) begin
        e.act = 1'b1;
        for (int c = 0; c < 3; c++) begin
          e.e0[c] = tmds_ref(m_pix[8*c +: 8], m_cnt[c]);
          e.e1[c] = e.e0[c];
        end
      end else begin
        for (int c = 0; c < 3; c++) m_cnt[c] = 0;
        e.e1[0] = tok({m_vs, m_hs}); e.e1[1] = tok(2'b00); e.e1[2] = tok(2'b00);
        e.e0 = e.e1;
        if (m_per == PER_PREAMBLE) e.e0[1] = tok(2'b01);
        if (m_per == PER_GUARD) begin
          e.e0[0] = 10'b1011001100; e.e0[1] = 10'b0100110011; e.e0[2] = 10'b1011001100;
        end
      end
      m_per = p; m_hs = hs; m_vs = vs; m_pix = px;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("hdmi", if0.symbols, o.e0);
    chk("dvi",  if1.symbols, o.e1);
    if (o.act) chk("decode", {6'd0, tmds_dec(if0.symbols[2]), tmds_dec(if0.symbols[1]),
                              tmds_dec(if0.symbols[0])}, {6'd0, o.pix});
  endtask

  initial begin
    m_per = PER_CONTROL; m_hs = 1'b0; m_vs = 1'b0; m_pix = '0;
    for (int c = 0; c < 3; c++) m_cnt[c] = 0;

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, PER_CONTROL, 24'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, PER_CONTROL, 24'h0, 1'b0, 1'b0);

    phase = "syncs";
    step(1'b0, PER_CONTROL, 24'h0, 1'b1, 1'b1);
    step(1'b0, PER_CONTROL, 24'h0, 1'b0, 1'b1);
    step(1'b0, PER_CONTROL, 24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, PER_CONTROL, 24'h0, 1'b0, 1'b0);

    phase = "preamble_guard";
    for (int i = 0; i < 8; i++) step(1'b0, PER_PREAMBLE, 24'hDEADBE, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, PER_GUARD, 24'h123456, 1'b1, 1'b0);

    phase = "active_zero";
    for (int i = 0; i < 3; i++) step(1'b0, PER_ACTIVE, 24'h000000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, PER_CONTROL, 24'hFFFFFF, 1'b0, 1'b0);

    phase = "active_ones_restart";
    step(1'b0, PER_ACTIVE, 24'hFFFFFF, 1'b0, 1'b0);
    step(1'b0, PER_CONTROL, 24'h0, 1'b0, 1'b0);
    step(1'b0, PER_ACTIVE, 24'h000000, 1'b0, 1'b0);
    step(1'b0, PER_GUARD, 24'h0, 1'b0, 1'b0);
    step(1'b0, PER_ACTIVE, 24'hA5C3F0, 1'b0, 1'b0);
    step(1'b0, PER_CONTROL, 24'h0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, PER_CONTROL, 24'h0, 1'b0, 1'b0);

    phase = "mid_line_reset";
    for (int i = 0; i < 3; i++) step(1'b0, PER_ACTIVE, 24'h0F0F01, 1'b0, 1'b0);
    step(1'b1, PER_ACTIVE, 24'h0F0F01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, PER_ACTIVE, 24'h000000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, PER_CONTROL, 24'h0, 1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) == 0), period_t'($urandom_range(0, 3)),
           24'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 2; i++) step(1'b0, PER_CONTROL, 24'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
